zmc_mem_scheduler: RTL
======================

// Module: zmc_mem_scheduler
// PURPOSE
//  Sequences the single-port ECC memory inside the memory controller.
//  Arbitrates whole AXI write and read bursts from the front-end channel FSMs, round-robin.
//  Generates per-beat word addresses for FIXED, INCR and WRAP bursts.
//  Runs the memory-initialisation sweep (zero-fill) on request and acknowledges completion.
// PARAMETERS
//  ADDR_W  32    AXI byte-address width
//  DEPTH   1024  memory depth in 32-bit words
//  MEM_AW  $clog2(DEPTH)  word-address width (derived; do not override)
// PORTS
//  zmc_top_clk       in   1       single clock, all logic on posedge
//  zmc_top_rstn      in   1       asynchronous active-low reset
//  zmc_top_sw_rst    in   1       synchronous soft reset, active-high
//  zmc_top_mem_init  in   1       init request pulse
//  wr_req            in   1       write burst pending (held until wr_done)
//  wr_addr           in   ADDR_W  burst start byte address (awaddr)
//  wr_len            in   4       beats-1 (awlen)
//  wr_burst          in   2       burst type (awburst)
//  wr_gnt            out  1       write burst owns memory
//  wr_beat           out  1       write beat accepted by memory this cycle
//  wr_done           out  1       1-cycle pulse on last write beat
//  rd_req/rd_addr/rd_len/rd_burst  in  1/ADDR_W/4/2  read equivalents (ar*)
//  rd_gnt/rd_beat/rd_done          out 1/1/1         read equivalents
//  mem_en            out  1       memory access valid
//  mem_we            out  1       1=write, 0=read
//  mem_addr          out  MEM_AW  word address
//  mem_init_wr       out  1       force zero data + matching ECC on this write
//  mem_ready         in   1       memory accepts current access
//  MEM_init_ACK      out  1       1-cycle pulse when init sweep finishes
// BEHAVIOUR
//  Reset (zmc_top_rstn low, async): all outputs 0, state IDLE, last_owner=RD, init_pend=0.
//  zmc_top_sw_rst high at a posedge: identical reset state next cycle.
//   Any burst/init in flight is abandoned; no done or ACK pulse.
//  States: IDLE, INIT, WR_BURST, RD_BURST.
//   - IDLE: priority is init_pend|zmc_top_mem_init, then requests.
//     Requests use round-robin: if both are pending, grant the one != last_owner.
//     Transition on the edge; gnt/mem_en assert in the first cycle of the new state (1-cycle grant latency).
//   - WR/RD_BURST: on entry, latch addr, len and burst. Beat counter=0; mem_addr=addr[MEM_AW+1:2].
//     mem_en=1 continuously; mem_we=1 for WR only.
//     Beat advances only when mem_ready=1: *_beat=1, counter++, mem_addr=next.
//     mem_ready=0 stalls; addr and counter hold.
//     Last beat (counter==len & mem_ready): *_done=1 that cycle, last_owner updated, ->IDLE.
//     gnt drops next cycle. IDLE lasts at least 1 cycle between bursts.
//   - INIT: mem_en=mem_we=mem_init_wr=1; mem_addr counts 0..DEPTH-1 on mem_ready.
//     After DEPTH-1 is accepted: ->IDLE, MEM_init_ACK=1 for exactly the next cycle.
//     wr_req/rd_req are ignored during INIT.
//  zmc_top_mem_init arriving in a burst or INIT sets init_pend.
//   Serviced at the next IDLE ahead of requests; cleared on entering INIT.
//  Next-address rules (word units, modulo DEPTH):
//   - FIXED (00): hold.
//   - INCR (01): +1; wraps DEPTH-1 -> 0.
//   - WRAP (10): len must be 1,3,7,15. Size=len+1, base=addr & ~(size-1), next=base|((addr+1)&(size-1)).
//     Any other len is treated as INCR.
//   - Reserved (11): treated as INCR.
//  Grants are mutually exclusive: wr_gnt & rd_gnt never both 1; neither is 1 in INIT.
//  A burst is atomic: no preemption by the other requester or by init.
// STRUCTURE
//  zmc_pkg (shared): typedef enum logic[1:0] burst_e {BURST_FIXED, BURST_INCR, BURST_WRAP, BURST_RSVD};
//   typedef enum sched_state_e {S_IDLE, S_INIT, S_WR, S_RD}; constant ZMC_BEAT_BYTES=4.
//  Sub-module zmc_burst_addr_gen: combinational (cur_addr, len, burst) -> next_addr.
//   Single instance on the latched burst; unit-testable alone.
// TESTING
//  1 DEPTH=16, mem_init pulse, mem_ready=1 -> mem_addr 0..15 with we=init_wr=1; ACK 1 cycle after addr 15.
//  2 wr_req addr=0x40 len=3 INCR -> wr_gnt 1 cycle later; mem_addr 16,17,18,19; wr_done with beat 4.
//  3 rd_req addr=0x0C len=3 WRAP -> mem_addr 3,0,1,2, mem_we=0; rd_done on addr 2.
//  4 wr_req+rd_req same cycle after reset -> write first; repeat simultaneous -> read first.
//  5 8-beat INCR write, mem_ready low 3 cycles at beat 2 -> addr/counter held; 8 wr_beat total, 1 wr_done.
//  6 sw_rst during beat 2 of a read -> all outputs 0 next cycle, no rd_done; mem_init mid-burst deferred, then sweeps.

Source files
------------

// File: rtl/zmc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : zmc_pkg
// Brief    : Shared types and constants for the ZMC memory scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package zmc_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_WR   = 2'd2,
    S_RD   = 2'd3
  } sched_state_e;

  localparam int ZMC_BEAT_BYTES = 4;
  localparam int BEAT_SHIFT     = $clog2(ZMC_BEAT_BYTES);

endpackage : zmc_pkg
`default_nettype wire

// File: rtl/zmc_mem_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : zmc_mem_scheduler_if
// Brief    : Front-end burst channels and memory access port of the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface zmc_mem_scheduler_if #(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 10
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        wr_len;
  logic [1:0]        wr_burst;
  logic              wr_gnt;
  logic              wr_beat;
  logic              wr_done;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [3:0]        rd_len;
  logic [1:0]        rd_burst;
  logic              rd_gnt;
  logic              rd_beat;
  logic              rd_done;

  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_init_wr;
  logic              mem_ready;

  // Scheduler side
  modport slave (
    input  wr_req, wr_addr, wr_len, wr_burst,
    output wr_gnt, wr_beat, wr_done,
    input  rd_req, rd_addr, rd_len, rd_burst,
    output rd_gnt, rd_beat, rd_done,
    output mem_en, mem_we, mem_addr, mem_init_wr,
    input  mem_ready
  );

  // Channel FSM / memory side
  modport master (
    output wr_req, wr_addr, wr_len, wr_burst,
    input  wr_gnt, wr_beat, wr_done,
    output rd_req, rd_addr, rd_len, rd_burst,
    input  rd_gnt, rd_beat, rd_done,
    input  mem_en, mem_we, mem_addr, mem_init_wr,
    output mem_ready
  );

endinterface : zmc_mem_scheduler_if
`default_nettype wire

// File: rtl/zmc_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : zmc_burst_addr_gen
// Brief    : Combinational next word address for FIXED/INCR/WRAP bursts.
// Revision : 1.0 - initial release
// ============================================================================
module zmc_burst_addr_gen
  import zmc_pkg::*;
#(
  parameter  int DEPTH  = 1024,
  localparam int MEM_AW = $clog2(DEPTH)
) (
  input  logic [MEM_AW-1:0] cur_addr,
  input  logic [3:0]        len,
  input  burst_e            burst,
  output logic [MEM_AW-1:0] next_addr
);

  logic [MEM_AW-1:0] incr_addr;
  logic [MEM_AW-1:0] wrap_mask;
  logic              wrap_ok;

  always_comb begin
    incr_addr = (cur_addr == MEM_AW'(DEPTH - 1)) ? '0 : cur_addr + 1'b1;
    // len is size-1, so for legal wrap lengths it is already the offset mask
    wrap_mask = MEM_AW'(len);
    wrap_ok   = (len == 4'd1) | (len == 4'd3) | (len == 4'd7) | (len == 4'd15);
    case (burst)
      BURST_FIXED: next_addr = cur_addr;
      BURST_WRAP:  next_addr = wrap_ok ? ((cur_addr & ~wrap_mask) |
                                          ((cur_addr + 1'b1) & wrap_mask))
                                       : incr_addr;
      default:     next_addr = incr_addr;
    endcase
  end

endmodule : zmc_burst_addr_gen
`default_nettype wire

// File: rtl/zmc_mem_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : zmc_mem_scheduler
// Brief    : Round-robin burst arbiter, beat address sequencer and init sweep.
// Revision : 1.0 - initial release
// ============================================================================
module zmc_mem_scheduler
  import zmc_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int DEPTH  = 1024,
  localparam int MEM_AW = $clog2(DEPTH)
) (
  input  logic               zmc_top_clk,
  input  logic               zmc_top_rstn,
  input  logic               zmc_top_sw_rst,
  input  logic               zmc_top_mem_init,
  output logic               MEM_init_ACK,
  zmc_mem_scheduler_if.slave bus
);

  sched_state_e      r_state;
  sched_state_e      w_state_nxt;
  logic              r_last_wr;
  logic              r_init_pend;
  logic              r_ack;
  logic [MEM_AW-1:0] r_addr;
  logic [MEM_AW-1:0] w_next_addr;
  logic [3:0]        r_len;
  logic [3:0]        r_cnt;
  burst_e            r_burst;
  logic              w_init_go;
  logic              w_pick_wr;
  logic              w_last_beat;
  logic              w_sweep_end;
  logic              unused_addr_bits;

  assign w_init_go   = r_init_pend | zmc_top_mem_init;
  // Write wins unless a read is also pending and the write side went last
  assign w_pick_wr   = bus.wr_req & (~bus.rd_req | ~r_last_wr);
  assign w_last_beat = (r_cnt == r_len);
  assign w_sweep_end = (r_state == S_INIT) & bus.mem_ready &
                       (r_addr == MEM_AW'(DEPTH - 1));
  assign MEM_init_ACK = r_ack;

  assign unused_addr_bits = ^{bus.wr_addr[ADDR_W-1:MEM_AW+BEAT_SHIFT], bus.wr_addr[BEAT_SHIFT-1:0],
                              bus.rd_addr[ADDR_W-1:MEM_AW+BEAT_SHIFT], bus.rd_addr[BEAT_SHIFT-1:0]};

  zmc_burst_addr_gen #(.DEPTH(DEPTH)) u_addr_gen (
    .cur_addr  (r_addr),
    .len       (r_len),
    .burst     (r_burst),
    .next_addr (w_next_addr)
  );

  always_ff @(posedge zmc_top_clk or negedge zmc_top_rstn) begin
    if (!zmc_top_rstn)       r_state <= S_IDLE;
    else if (zmc_top_sw_rst) r_state <= S_IDLE;
    else                     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    bus.wr_gnt      = 1'b0;
    bus.wr_beat     = 1'b0;
    bus.wr_done     = 1'b0;
    bus.rd_gnt      = 1'b0;
    bus.rd_beat     = 1'b0;
    bus.rd_done     = 1'b0;
    bus.mem_en      = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_init_wr = 1'b0;
    bus.mem_addr    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_init_go)       w_state_nxt = S_INIT;
        else if (w_pick_wr)  w_state_nxt = S_WR;
        else if (bus.rd_req) w_state_nxt = S_RD;
      end
      S_INIT: begin
        bus.mem_en      = 1'b1;
        bus.mem_we      = 1'b1;
        bus.mem_init_wr = 1'b1;
        bus.mem_addr    = r_addr;
        if (w_sweep_end) w_state_nxt = S_IDLE;
      end
      S_WR: begin
        bus.wr_gnt   = 1'b1;
        bus.mem_en   = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = r_addr;
        bus.wr_beat  = bus.mem_ready;
        bus.wr_done  = bus.mem_ready & w_last_beat;
        if (bus.wr_done) w_state_nxt = S_IDLE;
      end
      default: begin
        bus.rd_gnt   = 1'b1;
        bus.mem_en   = 1'b1;
        bus.mem_addr = r_addr;
        bus.rd_beat  = bus.mem_ready;
        bus.rd_done  = bus.mem_ready & w_last_beat;
        if (bus.rd_done) w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge zmc_top_clk or negedge zmc_top_rstn) begin
    if (!zmc_top_rstn) begin
      r_last_wr   <= 1'b0;
      r_init_pend <= 1'b0;
      r_ack       <= 1'b0;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_burst     <= BURST_FIXED;
    end else if (zmc_top_sw_rst) begin
      r_last_wr   <= 1'b0;
      r_init_pend <= 1'b0;
      r_ack       <= 1'b0;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_burst     <= BURST_FIXED;
    end else begin
      r_ack <= w_sweep_end;
      if ((r_state == S_IDLE) && w_init_go) r_init_pend <= 1'b0;
      else if (zmc_top_mem_init)            r_init_pend <= 1'b1;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_init_go) begin
            r_addr <= '0;
          end else if (w_pick_wr) begin
            r_addr  <= bus.wr_addr[MEM_AW+BEAT_SHIFT-1:BEAT_SHIFT];
            r_len   <= bus.wr_len;
            r_burst <= burst_e'(bus.wr_burst);
          end else if (bus.rd_req) begin
            r_addr  <= bus.rd_addr[MEM_AW+BEAT_SHIFT-1:BEAT_SHIFT];
            r_len   <= bus.rd_len;
            r_burst <= burst_e'(bus.rd_burst);
          end
        end
        S_INIT: begin
          if (bus.mem_ready) r_addr <= r_addr + 1'b1;
        end
        default: begin
          if (bus.mem_ready) begin
            r_addr <= w_next_addr;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last_beat) r_last_wr <= (r_state == S_WR);
          end
        end
      endcase
    end
  end

endmodule : zmc_mem_scheduler
`default_nettype wire
